// File: rtl/rrf_pkg.sv
// rtl/rrf_pkg.sv - shared RRF sizing and tag/map types
//
// Purpose: single source of the rename-register-file geometry for the
// allocator, decoder and ROB.
//   RRF_SIZE    : tag width
//   RRF_ENTRIES : number of RRF entries (2**RRF_SIZE)
//   rrf_tag_t   : one RRF tag
//   rrf_map_t   : one bit per RRF entry (1 = free)
package rrf_pkg;

  localparam int RRF_SIZE    = 7;
  localparam int RRF_ENTRIES = 1 << RRF_SIZE;

  typedef logic [RRF_SIZE-1:0]    rrf_tag_t;
  typedef logic [RRF_ENTRIES-1:0] rrf_map_t;

endpackage

// File: rtl/rrf_allocator_first2_finder.sv
// rtl/rrf_allocator_first2_finder.sv - lowest and second-lowest set bit of a map
//
// Module rrf_first2_finder (combinational).
// Ports:
//   map        in  2**W  bitmap, 1 = free
//   first_idx  out W     lowest set index (0 when none)
//   first_v    out 1     a lowest set index exists
//   second_idx out W     next-lowest set index (0 when none)
//   second_v   out 1     a second set index exists
module rrf_first2_finder #(
  parameter int W = 7
) (
  input  logic [(1<<W)-1:0] map,
  output logic [W-1:0]      first_idx,
  output logic              first_v,
  output logic [W-1:0]      second_idx,
  output logic              second_v
);

  always_comb begin
    first_idx  = '0;
    first_v    = 1'b0;
    second_idx = '0;
    second_v   = 1'b0;
    // Ascending scan: first hit fills slot 1, the next hit fills slot 2.
    for (int i = 0; i < (1 << W); i++) begin
      if (map[i]) begin
        if (!first_v) begin
          first_idx = i[W-1:0];
          first_v   = 1'b1;
        end else if (!second_v) begin
          second_idx = i[W-1:0];
          second_v   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rrf_allocator.sv
// rtl/rrf_allocator.sv - rename-register tag allocator with free bitmap
//
// Supplies the two lowest free RRF tags to the decoder each cycle, reclaims
// tags returned by the ROB and releases all tags on flush.
// Optional feature macro: RRF_ALLOC_RESERVE0_EN (tag 0 reserved as "no tag").
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   stall                       decode stalled, consumes ignored
//   flush                       release every tag
//   using_RRF_ptr_1/2           decoder consumed RRF_ptr_1/2
//   free_V1/2, free_tag_1/2     ROB retire-free strobes and tags
//   RRF_ptr_1/2, RRF_ptr_V1/2   registered lowest two free tags + valids
//   free_count                  registered number of free tags
//   rrf_full                    fewer than two free tags
module rrf_allocator #(
  parameter int RRF_SIZE = rrf_pkg::RRF_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                using_RRF_ptr_1,
  input  logic                using_RRF_ptr_2,
  input  logic                free_V1,
  input  logic                free_V2,
  input  logic [RRF_SIZE-1:0] free_tag_1,
  input  logic [RRF_SIZE-1:0] free_tag_2,
  output logic [RRF_SIZE-1:0] RRF_ptr_1,
  output logic [RRF_SIZE-1:0] RRF_ptr_2,
  output logic                RRF_ptr_V1,
  output logic                RRF_ptr_V2,
  output logic [RRF_SIZE:0]   free_count,
  output logic                rrf_full
);

  localparam int ENTRIES = 1 << RRF_SIZE;
`ifdef RRF_ALLOC_RESERVE0_EN
  localparam bit RESERVE0 = 1'b1;
`else
  localparam bit RESERVE0 = 1'b0;
`endif
  localparam logic [ENTRIES-1:0] RESET_MAP =
    RESERVE0 ? {{(ENTRIES-1){1'b1}}, 1'b0} : {ENTRIES{1'b1}};
  localparam int RESET_COUNT = ENTRIES - (RESERVE0 ? 1 : 0);
  localparam int RESET_P1    = RESERVE0 ? 1 : 0;
  localparam int RESET_P2    = RESERVE0 ? 2 : 1;

  logic [ENTRIES-1:0]  free_map;
  logic [ENTRIES-1:0]  next_map;
  logic [RRF_SIZE:0]   next_count;
  logic [RRF_SIZE-1:0] next_p1;
  logic [RRF_SIZE-1:0] next_p2;
  logic                next_v1;
  logic                next_v2;
  logic                c1;
  logic                c2;

  // A consume only counts when the pointer it names is genuinely free.
  assign c1 = using_RRF_ptr_1 & RRF_ptr_V1 & ~stall;
  assign c2 = using_RRF_ptr_2 & RRF_ptr_V2 & ~stall;

  // Clears first, then sets, so a free naming a just-consumed tag wins.
  always_comb begin
    next_map = free_map;
    if (c1)      next_map[RRF_ptr_1]  = 1'b0;
    if (c2)      next_map[RRF_ptr_2]  = 1'b0;
    if (free_V1) next_map[free_tag_1] = 1'b1;
    if (free_V2) next_map[free_tag_2] = 1'b1;
    if (flush)   next_map = RESET_MAP;
    if (RESERVE0) next_map[0] = 1'b0;
  end

  always_comb begin
    next_count = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      next_count = next_count + (RRF_SIZE+1)'(next_map[i]);
    end
  end

  rrf_first2_finder #(
    .W (RRF_SIZE)
  ) u_finder (
    .map        (next_map),
    .first_idx  (next_p1),
    .first_v    (next_v1),
    .second_idx (next_p2),
    .second_v   (next_v2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_map   <= RESET_MAP;
      RRF_ptr_1  <= RESET_P1[RRF_SIZE-1:0];
      RRF_ptr_2  <= RESET_P2[RRF_SIZE-1:0];
      RRF_ptr_V1 <= 1'b1;
      RRF_ptr_V2 <= 1'b1;
      free_count <= RESET_COUNT[RRF_SIZE:0];
      rrf_full   <= 1'b0;
    end else begin
      free_map   <= next_map;
      RRF_ptr_1  <= next_p1;
      RRF_ptr_2  <= next_p2;
      RRF_ptr_V1 <= next_v1;
      RRF_ptr_V2 <= next_v2;
      free_count <= next_count;
      rrf_full   <= (next_count < (RRF_SIZE+1)'(2));
    end
  end

endmodule

// File: tb/tb_rrf_allocator.sv
// tb/tb_rrf_allocator.sv - self-checking bench for rrf_allocator
module tb_rrf_allocator;
  import rrf_pkg::*;

  localparam int N = RRF_ENTRIES;
`ifdef RRF_ALLOC_RESERVE0_EN
  localparam int R0 = 1;
`else
  localparam int R0 = 0;
`endif

  typedef logic [3*RRF_SIZE+3:0] vec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                stall = 1'b0;
  logic                flush = 1'b0;
  logic                use1 = 1'b0;
  logic                use2 = 1'b0;
  logic                fv1 = 1'b0;
  logic                fv2 = 1'b0;
  logic [RRF_SIZE-1:0] ft1 = '0;
  logic [RRF_SIZE-1:0] ft2 = '0;
  logic [RRF_SIZE-1:0] p1;
  logic [RRF_SIZE-1:0] p2;
  logic                v1;
  logic                v2;
  logic [RRF_SIZE:0]   cnt;
  logic                full;

  int checks = 0;
  int errors = 0;

  // Reference model: set of free tags and the values it implies.
  bit                  mfree[N];
  logic [RRF_SIZE-1:0] e_p1, e_p2;
  logic                e_v1, e_v2, e_full;
  logic [RRF_SIZE:0]   e_cnt;

  rrf_allocator #(.RRF_SIZE(RRF_SIZE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .using_RRF_ptr_1 (use1),
    .using_RRF_ptr_2 (use2),
    .free_V1         (fv1),
    .free_V2         (fv2),
    .free_tag_1      (ft1),
    .free_tag_2      (ft2),
    .RRF_ptr_1       (p1),
    .RRF_ptr_2       (p2),
    .RRF_ptr_V1      (v1),
    .RRF_ptr_V2      (v2),
    .free_count      (cnt),
    .rrf_full        (full)
  );

  always #5 clk = ~clk;

  function automatic vec_t dut_vec();
    return {p1, v1, p2, v2, cnt, full};
  endfunction

  function automatic vec_t exp_vec();
    return {e_p1, e_v1, e_p2, e_v2, e_cnt, e_full};
  endfunction

  function automatic void model_refresh();
    int n = 0;
    int found = 0;
    e_p1 = '0; e_p2 = '0; e_v1 = 1'b0; e_v2 = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (mfree[i]) begin
        n++;
        if (found == 0) begin e_p1 = RRF_SIZE'(i); e_v1 = 1'b1; end
        else if (found == 1) begin e_p2 = RRF_SIZE'(i); e_v2 = 1'b1; end
        found++;
      end
    end
    e_cnt  = (RRF_SIZE+1)'(n);
    e_full = (n < 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mfree[i] = !(R0 == 1 && i == 0);
    model_refresh();
  endfunction

  function automatic void model_step(bit u1, bit u2, bit st, bit fl,
                                     bit f1, int t1, bit f2, int t2);
    if (fl) begin
      model_reset();
      return;
    end
    if (u1 && e_v1 && !st) mfree[e_p1] = 1'b0;
    if (u2 && e_v2 && !st) mfree[e_p2] = 1'b0;
    if (f1 && !(R0 == 1 && t1 == 0)) mfree[t1] = 1'b1;
    if (f2 && !(R0 == 1 && t2 == 0)) mfree[t2] = 1'b1;
    model_refresh();
  endfunction

  task automatic step(bit u1, bit u2, bit st, bit fl,
                      bit f1, int t1, bit f2, int t2);
    use1 = u1; use2 = u2; stall = st; flush = fl;
    fv1 = f1; ft1 = RRF_SIZE'(t1); fv2 = f2; ft2 = RRF_SIZE'(t2);
    @(posedge clk);
    #1;
    model_step(u1, u2, st, fl, f1, t1, f2, t2);
    use1 = 0; use2 = 0; stall = 0; flush = 0; fv1 = 0; fv2 = 0;
  endtask

  task automatic do_reset();
    use1 = 0; use2 = 0; stall = 0; flush = 0; fv1 = 0; fv2 = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (p1 !== RRF_SIZE'(R0) || p2 !== RRF_SIZE'(R0 + 1) || v1 !== 1'b1 || v2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ptrs got %0d/%0d v=%b%b want %0d/%0d v=11", p1, p2, v1, v2, R0, R0 + 1);
    end
    checks++;
    if (cnt !== (RRF_SIZE+1)'(N - R0) || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_count got %0d full=%b want %0d full=0", cnt, full, N - R0);
    end
  endtask

  task automatic test_pairs();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (p1 !== RRF_SIZE'(2*k + 2 + R0) || p2 !== RRF_SIZE'(2*k + 3 + R0)) begin
        errors++;
        $display("FAIL pair_step%0d got %0d/%0d want %0d/%0d", k, p1, p2, 2*k + 2 + R0, 2*k + 3 + R0);
      end
    end
    checks++;
    if (cnt !== (RRF_SIZE+1)'(N - R0 - 6)) begin
      errors++;
      $display("FAIL pair_count got %0d want %0d", cnt, N - R0 - 6);
    end
  endtask

  task automatic test_single_and_stall();
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (p1 !== RRF_SIZE'(R0) || p2 !== RRF_SIZE'(R0 + 2) || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL consume2_only got %0d/%0d want %0d/%0d", p1, p2, R0, R0 + 2);
    end
    step(1, 1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (p1 !== RRF_SIZE'(R0) || p2 !== RRF_SIZE'(R0 + 2) || cnt !== (RRF_SIZE+1)'(N - R0 - 1)) begin
      errors++;
      $display("FAIL stall_hold got %0d/%0d cnt %0d want %0d/%0d cnt %0d",
               p1, p2, cnt, R0, R0 + 2, N - R0 - 1);
    end
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int k = 0; k < (N - R0) / 2; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
    if ((N - R0) % 2 == 1) step(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b0 || cnt !== '0 || full !== 1'b1 || p1 !== '0 || p2 !== '0) begin
      errors++;
      $display("FAIL empty got v=%b%b cnt=%0d full=%b p=%0d/%0d want v=00 cnt=0 full=1 p=0/0",
               v1, v2, cnt, full, p1, p2);
    end
    step(0, 0, 0, 0, 1, 5, 1, 5);
    checks++;
    if (p1 !== RRF_SIZE'(5) || v1 !== 1'b1 || v2 !== 1'b0 || cnt !== (RRF_SIZE+1)'(1) || full !== 1'b1) begin
      errors++;
      $display("FAIL dup_free got p1=%0d v=%b%b cnt=%0d full=%b want p1=5 v=10 cnt=1 full=1",
               p1, v1, v2, cnt, full);
    end
    step(1, 0, 0, 0, 1, 5, 0, 0);
    checks++;
    if (p1 !== RRF_SIZE'(5) || cnt !== (RRF_SIZE+1)'(1)) begin
      errors++;
      $display("FAIL free_wins got p1=%0d cnt=%0d want p1=5 cnt=1", p1, cnt);
    end
    step(1, 0, 0, 0, 1, 9, 0, 0);
    checks++;
    if (p1 !== RRF_SIZE'(9) || v1 !== 1'b1 || cnt !== (RRF_SIZE+1)'(1)) begin
      errors++;
      $display("FAIL swap_last got p1=%0d v1=%b cnt=%0d want p1=9 v1=1 cnt=1", p1, v1, cnt);
    end
    step(1, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b0 || cnt !== '0) begin
      errors++;
      $display("FAIL drain_last got v=%b%b cnt=%0d want v=00 cnt=0", v1, v2, cnt);
    end
  endtask

  task automatic test_flush_and_async_reset();
    do_reset();
    for (int k = 0; k < 20; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (cnt !== (RRF_SIZE+1)'(N - R0 - 40) || p1 !== RRF_SIZE'(40 + R0)) begin
      errors++;
      $display("FAIL alloc40 got cnt=%0d p1=%0d want cnt=%0d p1=%0d", cnt, p1, N - R0 - 40, 40 + R0);
    end
    step(1, 1, 0, 1, 1, 3, 1, 50);
    checks++;
    if (p1 !== RRF_SIZE'(R0) || p2 !== RRF_SIZE'(R0 + 1) || v1 !== 1'b1 || v2 !== 1'b1 ||
        cnt !== (RRF_SIZE+1)'(N - R0) || full !== 1'b0) begin
      errors++;
      $display("FAIL flush got %h want %h", dut_vec(), exp_vec());
    end
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (p1 !== RRF_SIZE'(R0) || p2 !== RRF_SIZE'(R0 + 1) || v1 !== 1'b1 || v2 !== 1'b1 ||
        cnt !== (RRF_SIZE+1)'(N - R0) || full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got p=%0d/%0d v=%b%b cnt=%0d full=%b", p1, p2, v1, v2, cnt, full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit u1, u2, st, fl, f1, f2;
    int t1, t2;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      u1 = ($urandom_range(3) != 0);
      u2 = ($urandom_range(3) != 0);
      st = ($urandom_range(7) == 0);
      fl = ($urandom_range(99) == 0);
      f1 = ($urandom_range(7) < 4);
      f2 = ($urandom_range(7) < 3);
      t1 = $urandom_range(N - 1);
      t2 = ($urandom_range(3) == 0) ? t1 : $urandom_range(N - 1);
      step(u1, u2, st, fl, f1, t1, f2, t2);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d got p=%0d/%0d v=%b%b cnt=%0d full=%b want p=%0d/%0d v=%b%b cnt=%0d full=%b",
                 c, p1, p2, v1, v2, cnt, full, e_p1, e_p2, e_v1, e_v2, e_cnt, e_full);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Two consumes and two frees together keep the count steady.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, R0, 1, R0 + 1);
    checks++;
    if (cnt !== (RRF_SIZE+1)'(N - R0 - 2) || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL b2b_count got cnt=%0d want %0d", cnt, N - R0 - 2);
    end
  endtask

`ifdef RRF_ALLOC_RESERVE0_EN
  task automatic test_reserve0();
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    checks++;
    if (cnt !== (RRF_SIZE+1)'(N - 3) || p1 !== RRF_SIZE'(3)) begin
      errors++;
      $display("FAIL reserve0_free got cnt=%0d p1=%0d want cnt=%0d p1=3", cnt, p1, N - 3);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pairs();
    test_single_and_stall();
    test_exhaust();
    test_flush_and_async_reset();
    test_back_to_back();
`ifdef RRF_ALLOC_RESERVE0_EN
    test_reserve0();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rrf_allocator.md
# rrf_allocator

Rename-register (RRF) tag allocator that sits beside the decoder and supplies the two free RRF tags it consumes each cycle (`RRF_ptr_1/2` in, `using_RRF_ptr_1/2` out). It tracks which RRF entries are free in a bitmap. It reclaims tags that the ROB returns at retirement and releases every tag on a pipeline flush. Its tag outputs are registered, so the decoder sees stable pointers for a whole cycle.

## Interface
- `RRF_SIZE`, default 7: tag width; entry count is `2**RRF_SIZE`.
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `stall`  input  1  decode stalled; `using_RRF_ptr_*` are ignored while high.
- `flush`  input  1  pipeline flush; releases all tags.
- `using_RRF_ptr_1`  input  1  decoder consumed `RRF_ptr_1` this cycle.
- `using_RRF_ptr_2`  input  1  decoder consumed `RRF_ptr_2` this cycle (independent of `_1`).
- `free_V1`, `free_V2`  input  1 each  ROB retire-free strobes.
- `free_tag_1`, `free_tag_2`  input  `RRF_SIZE` each  tags being returned.
- `RRF_ptr_1`, `RRF_ptr_2`  output  `RRF_SIZE` each  lowest and second-lowest free tag (registered).
- `RRF_ptr_V1`, `RRF_ptr_V2`  output  1 each  the corresponding pointer is genuinely free.
- `free_count`  output  `RRF_SIZE+1`  number of free tags (registered).
- `rrf_full`  output  1  `free_count < 2`; the decoder's structural-stall request.

## Operation
- State: `free_map` (`2**RRF_SIZE` bits, 1 = free), plus the output registers.
- Effective consume:
  - `c1 = using_RRF_ptr_1 & RRF_ptr_V1 & ~stall`.
  - `c2 = using_RRF_ptr_2 & RRF_ptr_V2 & ~stall`.
  - A consume on an invalid pointer is ignored.
- Next-map update, in order:
  - Clear the bits of `RRF_ptr_1` if `c1` and `RRF_ptr_2` if `c2`.
  - Then set the bits of `free_tag_1` if `free_V1` and `free_tag_2` if `free_V2`.
  - Equal free tags on both ports set the bit once.
  - A free of an already-free tag leaves the bit set.
  - If a free and a consume name the same tag, the free wins.
- `flush`: the next map is all ones, overriding consume and free in that cycle.
- Next outputs are computed from the next map and registered:
  - `RRF_ptr_1` = lowest set index; `RRF_ptr_2` = next-lowest set index.
  - Each `_V` is low when no such index exists; its pointer is then 0.
- `free_count` is the population count of the next map, registered alongside the map (no separate increment/decrement arithmetic).
- Reset values: map all ones, `RRF_ptr_1`=0, `RRF_ptr_2`=1, both `_V`=1, `free_count`=`2**RRF_SIZE`, `rrf_full`=0.

## Timing
- Allocation latency is 1 cycle: a tag consumed at edge N disappears from the pointers after edge N, and the next free tags are presented in cycle N+1.
- Free-to-reuse latency is 1 cycle: a tag freed at edge N can appear as `RRF_ptr_1` in cycle N+1. It is never presented in the same cycle it is freed.
- Flush is asserted for one cycle; after that edge, outputs equal reset values.
- Flush and reset do not interact: asserting `rst_n` low mid-operation immediately forces reset values, independent of `clk`.
- Exhaustion:
  - With 1 free tag: `RRF_ptr_V1`=1, `RRF_ptr_V2`=0, `rrf_full`=1.
  - With 0 free tags: both `_V`=0.
  - A free and a consume in the same cycle at the empty boundary follow the update order above.
- Simultaneous 2 consumes and 2 frees leave `free_count` unchanged.

## Configuration
- `RRF_ALLOC_RESERVE0_EN`: tag 0 is reserved as "no tag".
  - Defined: bit 0 of the map is held at 0 and is never allocated, and frees of tag 0 are ignored. Reset/flush `free_count` = `2**RRF_SIZE - 1`, with `RRF_ptr_1`=1 and `RRF_ptr_2`=2.
  - Undefined: all tags are allocatable, as described above.

## Structure
- Package `rrf_pkg`: `RRF_SIZE`, `RRF_ENTRIES`, typedef `rrf_tag_t`, typedef `rrf_map_t`. The decoder and ROB use the same package.
- Sub-module `rrf_first2_finder`: combinational; takes the map and returns the two lowest set indices plus their valid bits. Used on the next-map path.
- The population count stays inline.

## Test plan
- Reset, no activity → `RRF_ptr_1`=0, `RRF_ptr_2`=1, both `_V`=1, `free_count`=128, `rrf_full`=0.
- `using_1` and `using_2` for 3 cycles → pointers step to (2,3), (4,5), (6,7); `free_count`=122.
- Consume only `_2` from (0,1) → next pointers (0,2); with `stall`=1 instead → pointers unchanged.
- Allocate 0..127, then `free_V1` with tag 5 and `free_V2` with tag 5 in one cycle → next cycle `RRF_ptr_1`=5, `RRF_ptr_V2`=0, `free_count`=1, `rrf_full`=1.
- 40 tags allocated, then `flush` with simultaneous consume and free → next cycle reset values; also drop `rst_n` between clock edges → outputs reset immediately.
- With `RRF_ALLOC_RESERVE0_EN` → reset gives (1,2) with `free_count`=127; a free of tag 0 leaves `free_count` unchanged.
